// File: rtl/ca_message_tx_pkg.sv
// Shared constants and types for the CA message return path.
//  - packet length, slot count
//  - cbus register offsets (12-bit, within the 16'h4000 window)
//  - capture FSM state codes and read-pipeline source select
package ca_message_tx_pkg;

    localparam int unsigned PKT_LEN  = 192;
    localparam int unsigned SLOT_NUM = 4;

    localparam logic [11:0] ADDR_CA_MESSAGE_START = 12'h000;
    localparam logic [11:0] ADDR_CA_MESSAGE_END   = 12'h0BF;
    localparam logic [11:0] ADDR_CAMSG_STATUS     = 12'h100;
    localparam logic [11:0] ADDR_CAMSG_DROP       = 12'h101;
    localparam logic [11:0] ADDR_CAMSG_RELEASE    = 12'h102;
    localparam logic [11:0] ADDR_CAMSG_CLEAR      = 12'h103;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFill = 2'd1,
        StDrop = 2'd2
    } cap_state_e;

    typedef enum logic [1:0] {
        RdZero = 2'd0,
        RdData = 2'd1,
        RdReg  = 2'd2
    } rd_sel_e;

endpackage

// File: rtl/sdpram_w8d1024.sv
// Simple dual-port RAM, 1024 x 8, one write port and one read port.
// Read latency 2: address sampled at edge n, data on rdata after edge n+1.
// No reset: contents survive rst.
//  clk    in   clock
//  we     in   write enable
//  waddr  in   write address
//  wdata  in   write data
//  raddr  in   read address
//  rdata  out  read data (2 cycles after raddr)
module sdpram_w8d1024 (
    input  logic       clk,
    input  logic       we,
    input  logic [9:0] waddr,
    input  logic [7:0] wdata,
    input  logic [9:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] mem [1024];
    logic [7:0] rd_stage;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rd_stage <= mem[raddr];
        rdata    <= rd_stage;
    end

endmodule

// File: rtl/ca_message_tx.sv
// CA message return path: captures 192-byte packets from the TS byte stream into
// four 256-byte RAM slots; the CPU reads the head slot over cbus and releases it.
// Optional build macro CA_MSG_TX_LEN_CHECK_EN: commit only packets of exactly
// PKT_LEN bytes, otherwise discard and count as a drop.
//  clk, rst            clock, asynchronous active-high reset
//  ts_valid/data/sop/eop  input byte stream
//  ts_full             all slots occupied (registered)
//  cbus_addr/wdata/we/oe  CPU bus; cbus_rdata returns 4 cycles after oe
//  cpu_int             packet count > 0 (registered)
module ca_message_tx
    import ca_message_tx_pkg::*;
#(
    parameter int unsigned CBUS_ADDR_WIDTH = 12,
    parameter int unsigned CBUS_DATA_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ts_valid,
    input  logic [7:0]                 ts_data,
    input  logic                       ts_sop,
    input  logic                       ts_eop,
    output logic                       ts_full,
    input  logic [CBUS_ADDR_WIDTH-1:0] cbus_addr,
    input  logic [CBUS_DATA_WIDTH-1:0] cbus_wdata,
    input  logic                       cbus_we,
    input  logic                       cbus_oe,
    output logic [CBUS_DATA_WIDTH-1:0] cbus_rdata,
    output logic                       cpu_int
);

    cap_state_e state_q, state_d;
    logic [7:0] byte_cnt_q, byte_cnt_d;
    logic [7:0] beat_idx;
    logic       accept_beat;
    logic [2:0] wr_slot_q, rd_slot_q;
    logic [2:0] count;
    logic       slot_full;
    logic       commit, drop_inc, release_req, clear_req;
    logic [7:0] drop_cnt_q;
    logic       ovf_q;
    logic       ram_we;
    logic [9:0] ram_waddr;
    logic [9:0] ram_raddr_q;
    logic [7:0] ram_rdata;
    logic       unused_wdata;

    // Pointers carry a wrap bit so that 4 pending packets differ from 0.
    assign count     = wr_slot_q - rd_slot_q;
    assign slot_full = (count == 3'(SLOT_NUM));

    // ---------------- capture FSM ----------------
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        accept_beat = 1'b0;
        commit      = 1'b0;
        drop_inc    = 1'b0;
        ram_we      = 1'b0;
        // sop always restarts at offset 0, also mid-packet
        beat_idx    = ts_sop ? 8'd0 : byte_cnt_q;
        ram_waddr   = {wr_slot_q[1:0], beat_idx};

        case (state_q)
            StIdle: begin
                if (ts_valid && ts_sop) begin
                    if (slot_full) begin
                        if (ts_eop) begin
                            drop_inc = 1'b1;
                        end else begin
                            state_d = StDrop;
                        end
                    end else begin
                        accept_beat = 1'b1;
                    end
                end
            end
            StFill: begin
                if (ts_valid) begin
                    accept_beat = 1'b1;
                end
            end
            StDrop: begin
                if (ts_valid && ts_eop) begin
                    drop_inc = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (accept_beat) begin
            ram_we     = (beat_idx < 8'(PKT_LEN));
            byte_cnt_d = (beat_idx == 8'hFF) ? 8'hFF : beat_idx + 8'd1;
            state_d    = StFill;
            if (ts_eop) begin
                state_d = StIdle;
`ifdef CA_MSG_TX_LEN_CHECK_EN
                if (beat_idx == 8'(PKT_LEN - 1)) begin
                    commit = 1'b1;
                end else begin
                    drop_inc = 1'b1;
                end
`else
                commit = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            byte_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    // ---------------- slot pointers, status, drop counter ----------------
    assign release_req  = cbus_we && (cbus_addr == ADDR_CAMSG_RELEASE) && (count != 3'd0);
    assign clear_req    = cbus_we && (cbus_addr == ADDR_CAMSG_CLEAR) && cbus_wdata[0];
    assign unused_wdata = ^cbus_wdata[CBUS_DATA_WIDTH-1:1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_slot_q  <= 3'd0;
            rd_slot_q  <= 3'd0;
            drop_cnt_q <= 8'd0;
            ovf_q      <= 1'b0;
            ts_full    <= 1'b0;
            cpu_int    <= 1'b0;
        end else begin
            if (commit) begin
                wr_slot_q <= wr_slot_q + 3'd1;
            end
            if (release_req) begin
                rd_slot_q <= rd_slot_q + 3'd1;
            end
            // A drop in the same cycle as a clear keeps the drop visible.
            if (drop_inc) begin
                ovf_q <= 1'b1;
                if (drop_cnt_q != 8'hFF) begin
                    drop_cnt_q <= drop_cnt_q + 8'd1;
                end
            end else if (clear_req) begin
                ovf_q      <= 1'b0;
                drop_cnt_q <= 8'd0;
            end
            ts_full <= slot_full;
            cpu_int <= (count != 3'd0);
        end
    end

    // ---------------- RAM ----------------
    sdpram_w8d1024 u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ts_data),
        .raddr (ram_raddr_q),
        .rdata (ram_rdata)
    );

    // ---------------- cbus read pipeline ----------------
    // c1 latches the decode (and the head slot), c2/c3 cover RAM latency,
    // c4 muxes into cbus_rdata. Register values are snapshotted at c1.
    rd_sel_e    rd_sel_c;
    logic [7:0] rd_reg_c;
    logic       rd1_v_q, rd2_v_q, rd3_v_q;
    rd_sel_e    rd1_sel_q, rd2_sel_q, rd3_sel_q;
    logic [7:0] rd1_reg_q, rd2_reg_q, rd3_reg_q;

    always_comb begin
        rd_sel_c = RdZero;
        rd_reg_c = 8'h00;
        if ((cbus_addr[11:8] == ADDR_CA_MESSAGE_START[11:8]) &&
            (cbus_addr[7:0] <= ADDR_CA_MESSAGE_END[7:0])) begin
            rd_sel_c = RdData;
        end else if (cbus_addr == ADDR_CAMSG_STATUS) begin
            rd_sel_c = RdReg;
            rd_reg_c = {ovf_q, 4'b0000, count};
        end else if (cbus_addr == ADDR_CAMSG_DROP) begin
            rd_sel_c = RdReg;
            rd_reg_c = drop_cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd1_v_q     <= 1'b0;
            rd2_v_q     <= 1'b0;
            rd3_v_q     <= 1'b0;
            rd1_sel_q   <= RdZero;
            rd2_sel_q   <= RdZero;
            rd3_sel_q   <= RdZero;
            rd1_reg_q   <= 8'h00;
            rd2_reg_q   <= 8'h00;
            rd3_reg_q   <= 8'h00;
            ram_raddr_q <= 10'd0;
            cbus_rdata  <= '0;
        end else begin
            rd1_v_q     <= cbus_oe;
            rd1_sel_q   <= rd_sel_c;
            rd1_reg_q   <= rd_reg_c;
            ram_raddr_q <= {rd_slot_q[1:0], cbus_addr[7:0]};
            rd2_v_q     <= rd1_v_q;
            rd2_sel_q   <= rd1_sel_q;
            rd2_reg_q   <= rd1_reg_q;
            rd3_v_q     <= rd2_v_q;
            rd3_sel_q   <= rd2_sel_q;
            rd3_reg_q   <= rd2_reg_q;
            if (rd3_v_q) begin
                case (rd3_sel_q)
                    RdData:  cbus_rdata <= ram_rdata;
                    RdReg:   cbus_rdata <= rd3_reg_q;
                    default: cbus_rdata <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ca_message_tx.sv
// Bench for ca_message_tx: directed packets and cbus accesses, a packet-level
// reference model checked every cycle, plus hand-computed literal expectations.
`timescale 1ns/1ps
module tb_ca_message_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ts_valid = 1'b0;
    logic [7:0]  ts_data = 8'h00;
    logic        ts_sop = 1'b0;
    logic        ts_eop = 1'b0;
    logic        ts_full;
    logic [11:0] cbus_addr = 12'h000;
    logic [7:0]  cbus_wdata = 8'h00;
    logic        cbus_we = 1'b0;
    logic        cbus_oe = 1'b0;
    logic [7:0]  cbus_rdata;
    logic        cpu_int;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ca_message_tx dut (
        .clk        (clk),
        .rst        (rst),
        .ts_valid   (ts_valid),
        .ts_data    (ts_data),
        .ts_sop     (ts_sop),
        .ts_eop     (ts_eop),
        .ts_full    (ts_full),
        .cbus_addr  (cbus_addr),
        .cbus_wdata (cbus_wdata),
        .cbus_we    (cbus_we),
        .cbus_oe    (cbus_oe),
        .cbus_rdata (cbus_rdata),
        .cpu_int    (cpu_int)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h want %02h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int         due;
        logic [7:0] val;
    } rd_t;

    logic [7:0] mem_m [4][256];
    int         npend, head, drop_m, mode, idx, cyc;
    bit         ovf_m;
    rd_t        rdq[$];
    logic [7:0] rdata_exp = 8'h00;
    bit         full_exp = 1'b0;
    bit         int_exp = 1'b0;

    function automatic logic [7:0] model_read(input logic [11:0] a);
        if (a[11:8] == 4'h0) return (a[7:0] < 8'hC0) ? mem_m[head][a[7:0]] : 8'h00;
        if (a == 12'h100) return {ovf_m, 4'b0000, 3'(npend)};
        if (a == 12'h101) return 8'(drop_m);
        return 8'h00;
    endfunction

    initial begin
        bit  commit_e, drop_e, take;
        int  slot, np0;
        rd_t r;
        for (int s = 0; s < 4; s++) for (int b = 0; b < 256; b++) mem_m[s][b] = 8'h00;
        npend = 0; head = 0; drop_m = 0; ovf_m = 0; mode = 0; idx = 0; cyc = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                npend = 0; head = 0; drop_m = 0; ovf_m = 0; mode = 0; idx = 0;
                rdq.delete();
                rdata_exp = 8'h00; full_exp = 0; int_exp = 0;
            end else begin
                cyc++;
                np0 = npend;
                // flags reflect the packet count as it stood one cycle earlier
                full_exp = (np0 == 4);
                int_exp  = (np0 != 0);
                while (rdq.size() != 0 && rdq[0].due <= cyc) begin
                    r = rdq.pop_front();
                    rdata_exp = r.val;
                end
                if (cbus_oe) begin
                    r.due = cyc + 3;
                    r.val = model_read(cbus_addr);
                    rdq.push_back(r);
                end
                commit_e = 0; drop_e = 0; take = 0;
                slot = (head + np0) % 4;
                if (ts_valid) begin
                    if (ts_sop && mode != 2) begin
                        if (mode == 0 && np0 == 4) begin
                            if (ts_eop) drop_e = 1; else mode = 2;
                        end else begin
                            idx = 0; mode = 1; take = 1;
                        end
                    end else if (mode == 1) begin
                        take = 1;
                    end else if (mode == 2 && ts_eop) begin
                        drop_e = 1; mode = 0;
                    end
                end
                if (take) begin
                    if (idx < 192) mem_m[slot][idx] = ts_data;
                    if (idx < 255) idx++;
                    if (ts_eop) begin
                        mode = 0;
`ifdef CA_MSG_TX_LEN_CHECK_EN
                        if (idx == 192) commit_e = 1; else drop_e = 1;
`else
                        commit_e = 1;
`endif
                    end
                end
                if (commit_e) npend++;
                if (cbus_we && cbus_addr == 12'h102 && np0 != 0) begin
                    npend--;
                    head = (head + 1) % 4;
                end
                if (drop_e) begin
                    if (drop_m < 255) drop_m++;
                    ovf_m = 1;
                end else if (cbus_we && cbus_addr == 12'h103 && cbus_wdata[0]) begin
                    drop_m = 0;
                    ovf_m = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(posedge clk);
            #2;
            chk("cyc ts_full", {7'b0, ts_full}, {7'b0, full_exp});
            chk("cyc cpu_int", {7'b0, cpu_int}, {7'b0, int_exp});
            chk("cyc cbus_rdata", cbus_rdata, rdata_exp);
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_pkt(input int len, input int base, input bit with_eop);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            ts_valid = 1'b1;
            ts_data  = 8'(base + i);
            ts_sop   = (i == 0);
            ts_eop   = with_eop && (i == len - 1);
        end
        @(negedge clk);
        ts_valid = 1'b0; ts_sop = 1'b0; ts_eop = 1'b0;
    endtask

    task automatic cb_write(input logic [11:0] a, input logic [7:0] d);
        @(negedge clk);
        cbus_addr = a; cbus_wdata = d; cbus_we = 1'b1;
        @(negedge clk);
        cbus_we = 1'b0;
    endtask

    task automatic read_expect(input string name, input logic [11:0] a, input logic [7:0] exp);
        @(negedge clk);
        cbus_addr = a; cbus_oe = 1'b1;
        @(negedge clk);
        cbus_oe = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk(name, cbus_rdata, exp);
    endtask

    task automatic read_window();
        for (int a = 0; a < 192; a++) begin
            @(negedge clk);
            cbus_addr = 12'(a); cbus_oe = 1'b1;
        end
        @(negedge clk);
        cbus_oe = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("reset ts_full", {7'b0, ts_full}, 8'h00);
        chk("reset cpu_int", {7'b0, cpu_int}, 8'h00);
        chk("reset rdata", cbus_rdata, 8'h00);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: one full packet, data = index
        send_pkt(192, 0, 1);
        @(posedge clk); #1;
        chk("t1 cpu_int", {7'b0, cpu_int}, 8'h01);
        read_window();
        cb_write(12'h005, 8'hEE);
        read_expect("t1 data 005", 12'h005, 8'h05);
        read_expect("t1 data 0bf", 12'h0BF, 8'hBF);
        read_expect("t1 pad 0c0", 12'h0C0, 8'h00);
        read_expect("t1 status", 12'h100, 8'h01);
        read_expect("t1 drop", 12'h101, 8'h00);
        read_expect("t1 unmapped", 12'h200, 8'h00);

        // 2: release, then extra release on empty
        cb_write(12'h102, 8'h00);
        @(posedge clk); #1;
        chk("t2 cpu_int", {7'b0, cpu_int}, 8'h00);
        read_expect("t2 status", 12'h100, 8'h00);
        cb_write(12'h102, 8'h00);
        read_expect("t2 status empty", 12'h100, 8'h00);

        // 3: five packets, fifth dropped
        for (int k = 0; k < 4; k++) send_pkt(192, k * 16 + 1, 1);
        @(posedge clk); #1;
        chk("t3 ts_full", {7'b0, ts_full}, 8'h01);
        send_pkt(192, 8'h41, 1);
        read_expect("t3 drop", 12'h101, 8'h01);
        read_expect("t3 status", 12'h100, 8'h84);
        read_expect("t3 head data", 12'h000, 8'h01);
        cb_write(12'h103, 8'h01);
        read_expect("t3 status clr", 12'h100, 8'h04);
        read_expect("t3 drop clr", 12'h101, 8'h00);
        for (int k = 0; k < 4; k++) cb_write(12'h102, 8'h00);
        read_expect("t3 drained", 12'h100, 8'h00);

        // 4: short packet
        send_pkt(100, 8'hA0, 1);
`ifdef CA_MSG_TX_LEN_CHECK_EN
        read_expect("t4 status", 12'h100, 8'h80);
        read_expect("t4 drop", 12'h101, 8'h01);
        cb_write(12'h103, 8'h01);
        read_expect("t4 status clr", 12'h100, 8'h00);
`else
        read_expect("t4 status", 12'h100, 8'h01);
        read_expect("t4 last byte", 12'h063, 8'h03);
        read_expect("t4 stale tail", 12'h064, 8'h65);
        read_window();
        cb_write(12'h102, 8'h00);
`endif

        // 5: restart mid-packet
        send_pkt(50, 8'h33, 0);
        send_pkt(192, 8'h55, 1);
        read_expect("t5 status", 12'h100, 8'h01);
        read_expect("t5 byte0", 12'h000, 8'h55);
        read_expect("t5 byte49", 12'h031, 8'h86);
        read_expect("t5 byte191", 12'h0BF, 8'h14);
        read_window();
        cb_write(12'h102, 8'h00);

        // 6: reset mid-packet and mid-read
        send_pkt(192, 8'h20, 1);
        send_pkt(60, 8'h10, 0);
        @(negedge clk);
        cbus_addr = 12'h100; cbus_oe = 1'b1;
        @(negedge clk);
        cbus_oe = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6 rst rdata", cbus_rdata, 8'h00);
        chk("t6 rst ts_full", {7'b0, ts_full}, 8'h00);
        chk("t6 rst cpu_int", {7'b0, cpu_int}, 8'h00);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        read_expect("t6 status", 12'h100, 8'h00);
        send_pkt(192, 8'h77, 1);
        read_expect("t6 new status", 12'h100, 8'h01);
        read_expect("t6 slot0 byte0", 12'h000, 8'h77);
        read_window();

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
